// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ser_pkg
//  Description : Shared types and constants for the serial write transmitter:
//                FSM state encoding, bus offset decode, window decode and the
//                word-framing helper. Macro SER_SDWR_PARITY_EN adds an
//                odd-parity ninth bit to every word.
//  Revision    : 1.0 - initial release
// ============================================================================
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_GAP  = 2'd3
  } ser_state_e;

  localparam logic [3:0] OFS_DATA = 4'h0;
  localparam logic [3:0] OFS_CTRL = 4'h1;
  localparam logic [1:0] WIN_SEL  = 2'b01;

`ifdef SER_SDWR_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd8;
`else
  localparam logic [3:0] LAST_BIT = 4'd7;
`endif

  // Data left-justified with its odd-parity bit in the LSB; when parity is
  // disabled the LSB is simply never shifted out.
  function automatic logic [8:0] frame_word(input logic [7:0] d);
    return {d, ~^d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ser_clkdiv.sv
`default_nettype none
// ============================================================================
//  Module      : ser_clkdiv
//  Description : Phase timer. Loads the divider value at each phase start,
//                counts down to zero and flags terminal count, so a phase
//                lasts div+1 clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_clkdiv (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] div,
  output logic       tc
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Reload on phase start, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = div;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ser_sdwr_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ser_sdwr_tx
//  Description : Bus-mapped serial write transmitter. Data writes are framed
//                and shifted MSB first with a programmable serial clock; a
//                one-deep hold register queues the next word. Macro
//                SER_SDWR_PARITY_EN appends an odd-parity ninth bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_sdwr_tx #(
  parameter logic [3:0] DIV_RST = 4'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sser_n,
  input  logic [13:4] ba,
  input  logic        br_w,
  input  logic [7:0]  bd,
  output logic        sdwr,
  output logic        sclk_o,
  output logic        sframe_n,
  output logic        busy,
  output logic        done,
  output logic        ovr
);

  import ser_pkg::*;

  ser_state_e state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [3:0] div_q, div_d;
  logic       ovr_q, ovr_d;
  logic       done_q, done_d;
  logic       sdwr_q, sdwr_d;
  logic       sclk_q, sclk_d;
  logic       sframe_n_q, sframe_n_d;
  logic       qual_q, qual_d;

  logic       qual, accept, wr_data, wr_ctrl;
  logic       div_load, div_tc;
  logic       gap_exit, start_word;
  logic [7:0] start_data;
  logic       unused_bits;

  assign qual    = ~sser_n & (ba[13:12] == WIN_SEL) & ~br_w;
  assign accept  = qual & ~qual_q;
  assign wr_data = accept & (ba[7:4] == OFS_DATA);
  assign wr_ctrl = accept & (ba[7:4] == OFS_CTRL);
  assign unused_bits = ^{ba[11:8], bd[6:4]};

  ser_clkdiv u_clkdiv (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (div_load),
    .div   (div_q),
    .tc    (div_tc)
  );

  // Next-state: phase sequencing, hold/overrun handling and control writes
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    div_d       = div_q;
    ovr_d       = ovr_q;
    done_d      = 1'b0;
    sdwr_d      = sdwr_q;
    sclk_d      = sclk_q;
    sframe_n_d  = sframe_n_q;
    qual_d      = qual;
    div_load    = 1'b0;
    gap_exit    = 1'b0;
    start_word  = 1'b0;
    start_data  = bd;

    case (state_q)
      ST_IDLE: begin
        if (wr_data) begin
          start_word = 1'b1;
          start_data = bd;
        end
      end
      ST_LOW: begin
        if (div_tc) begin
          state_d  = ST_HIGH;
          sclk_d   = 1'b1;
          div_load = 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_tc) begin
          sclk_d   = 1'b0;
          div_load = 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d    = ST_GAP;
            sframe_n_d = 1'b1;
            sdwr_d     = 1'b1;
            done_d     = 1'b1;
          end else begin
            state_d = ST_LOW;
            sdwr_d  = shift_q[7];
            shift_d = {shift_q[6:0], 1'b1};
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (div_tc) begin
          gap_exit = 1'b1;
          if (hold_full_q) begin
            start_word  = 1'b1;
            start_data  = hold_q;
            hold_full_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write landing on the GAP exit clock is queued behind the held word,
    // or sent directly when nothing is held, so it is never counted as overrun.
    if (wr_data && (state_q != ST_IDLE)) begin
      if (gap_exit && !hold_full_q) begin
        start_word = 1'b1;
        start_data = bd;
      end else if (!hold_full_q || gap_exit) begin
        hold_d      = bd;
        hold_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    // New divider only affects phases that start after this write
    if (wr_ctrl) begin
      div_d = bd[3:0];
      if (bd[7]) begin
        ovr_d = 1'b0;
      end
    end

    if (start_word) begin
      state_d              = ST_LOW;
      {sdwr_d, shift_d}    = frame_word(start_data);
      sclk_d               = 1'b0;
      sframe_n_d           = 1'b0;
      bit_d                = 4'd0;
      div_load             = 1'b1;
    end
  end

  // State and registered outputs; edge detector primed high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'hFF;
      bit_q       <= 4'd0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      div_q       <= DIV_RST;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      sdwr_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sframe_n_q  <= 1'b1;
      qual_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      div_q       <= div_d;
      ovr_q       <= ovr_d;
      done_q      <= done_d;
      sdwr_q      <= sdwr_d;
      sclk_q      <= sclk_d;
      sframe_n_q  <= sframe_n_d;
      qual_q      <= qual_d;
    end
  end

  assign sdwr     = sdwr_q;
  assign sclk_o   = sclk_q;
  assign sframe_n = sframe_n_q;
  assign done     = done_q;
  assign ovr      = ovr_q;
  assign busy     = (state_q != ST_IDLE) | hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_ser_sdwr_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ser_sdwr_tx
//  Description : Directed self-checking bench for ser_sdwr_tx. A negedge
//                monitor captures each serial frame (bits, length, sclk_o
//                rise positions); the main sequence compares against
//                hand-computed words. Honours SER_SDWR_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_sdwr_tx;

`ifdef SER_SDWR_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sser_n = 1'b1;
  logic [13:4] ba = '0;
  logic        br_w = 1'b0;
  logic [7:0]  bd = 8'h00;
  logic        sdwr, sclk_o, sframe_n, busy, done, ovr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ser_sdwr_tx #(.DIV_RST(4'd3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sser_n   (sser_n),
    .ba       (ba),
    .br_w     (br_w),
    .bd       (bd),
    .sdwr     (sdwr),
    .sclk_o   (sclk_o),
    .sframe_n (sframe_n),
    .busy     (busy),
    .done     (done),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- frame monitor ----------------
  int         m_half = 4;
  logic [8:0] m_bits = '0;
  int         m_nb = 0, m_fi = 0;
  bit         m_bad = 0;
  logic       m_prev_sclk = 1'b0, m_prev_fn = 1'b1;
  logic [8:0] q_bits[$];
  int         q_nb[$], q_len[$];
  bit         q_bad[$];
  int         frame_end_cyc = -1, last_gap = -1, done_cnt = 0, done_cyc = -2;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_bits <= '0; m_nb <= 0; m_fi <= 0; m_bad <= 0;
      m_prev_sclk <= 1'b0; m_prev_fn <= 1'b1;
    end else begin
      m_prev_sclk <= sclk_o;
      m_prev_fn   <= sframe_n;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (!sframe_n) begin
        if (m_prev_fn) last_gap <= cyc - frame_end_cyc;
        m_fi <= m_fi + 1;
        if (sclk_o && !m_prev_sclk) begin
          m_bits <= {m_bits[7:0], sdwr};
          m_nb   <= m_nb + 1;
          if (m_fi != m_half * (2 * m_nb + 1)) m_bad <= 1;
        end
      end else if (!m_prev_fn) begin
        q_bits.push_back(m_bits);
        q_nb.push_back(m_nb);
        q_len.push_back(m_fi);
        q_bad.push_back(m_bad);
        frame_end_cyc <= cyc;
        m_bits <= '0; m_nb <= 0; m_fi <= 0; m_bad <= 0;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [13:4] addr(input logic [13:0] a);
    return a[13:4];
  endfunction

  function automatic logic [8:0] exp_word(input logic [7:0] d);
`ifdef SER_SDWR_PARITY_EN
    return {d, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0};
`else
    return {1'b0, d};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [7:0] d, input logic rw);
    sser_n = 1'b0; ba = addr(a); bd = d; br_w = rw;
    @(posedge clk); #1;
    sser_n = 1'b1; br_w = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int k = 0;
    while (q_bits.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_timeout"}, 32'(q_bits.size() >= n), 1);
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input int half);
    chk({tag, "_present"}, 32'(q_bits.size() > 0), 1);
    if (q_bits.size() > 0) begin
      chk({tag, "_bits"}, 32'(q_bits.pop_front()), 32'(exp_word(d)));
      chk({tag, "_nbits"}, 32'(q_nb.pop_front()), 32'(NB));
      chk({tag, "_flen"}, 32'(q_len.pop_front()), 32'(2 * half * NB));
      chk({tag, "_sclk_timing"}, 32'(q_bad.pop_front()), 0);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int dc;
    logic [8:0] w;

    // Reset with the qualifier already asserted: must be ignored afterwards
    sser_n = 1'b0; ba = addr(14'h1000); bd = 8'hA5; br_w = 1'b0;
    tick(3);
    chk("rst_sdwr", sdwr, 1);
    chk("rst_sclk", sclk_o, 0);
    chk("rst_sframe_n", sframe_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    tick(6);
    chk("primed_busy", busy, 0);
    chk("primed_frame", sframe_n, 1);
    sser_n = 1'b1;
    tick(2);

    // 8'hA5 at div=3: load visibility, then frame shape and done timing
    sser_n = 1'b0; ba = addr(14'h1000); bd = 8'hA5; br_w = 1'b0;
    @(posedge clk); #1;
    chk("load_sframe_n", sframe_n, 0);
    chk("load_sdwr_bit7", sdwr, 1);
    chk("load_sclk", sclk_o, 0);
    chk("load_busy", busy, 1);
    sser_n = 1'b1;
    wait_frames("a5", 1, 300);
    check_word("a5", 8'hA5, 4);
    chk("a5_done_at_gap", 32'(done_cyc), 32'(frame_end_cyc));
    chk("a5_done_cnt", 32'(done_cnt), 1);
    tick(8);
    chk("a5_idle_busy", busy, 0);
    chk("a5_idle_sdwr", sdwr, 1);

    // Back-to-back through the hold register
    bus_write(14'h1000, 8'h3C, 1'b0);
    tick(10);
    bus_write(14'h1000, 8'hFF, 1'b0);
    wait_frames("b2b", 2, 600);
    check_word("b2b_w0", 8'h3C, 4);
    check_word("b2b_w1", 8'hFF, 4);
    chk("b2b_gap", 32'(last_gap), 4);
    chk("b2b_ovr", ovr, 0);
    tick(8);

    // Third write while the hold is full: dropped, sticky overrun
    bus_write(14'h1000, 8'h3C, 1'b0);
    tick(5);
    bus_write(14'h1000, 8'hFF, 1'b0);
    tick(5);
    bus_write(14'h1000, 8'h55, 1'b0);
    chk("ovr_set", ovr, 1);
    wait_frames("ovr", 2, 600);
    check_word("ovr_w0", 8'h3C, 4);
    check_word("ovr_w1", 8'hFF, 4);
    tick(200);
    chk("ovr_third_dropped", 32'(q_bits.size()), 0);
    chk("ovr_sticky", ovr, 1);
    chk("ovr_idle_busy", busy, 0);

    // Control write clears overrun and sets div=0
    bus_write(14'h1010, 8'h80, 1'b0);
    chk("ctrl_ovr_clr", ovr, 0);
    m_half = 1;
    bus_write(14'h1000, 8'hC3, 1'b0);
    wait_frames("div0", 1, 200);
    check_word("div0", 8'hC3, 1);
    tick(6);
    bus_write(14'h1010, 8'h03, 1'b0);
    m_half = 4;

    // Write landing exactly on the GAP exit clock with the hold full
    bus_write(14'h1000, 8'h11, 1'b0);
    tick(3);
    bus_write(14'h1000, 8'h22, 1'b0);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("gapx_done_seen", 32'(done), 1);
    repeat (3) @(posedge clk);
    #1;
    sser_n = 1'b0; ba = addr(14'h1000); bd = 8'h33;
    @(posedge clk); #1;
    sser_n = 1'b1;
    wait_frames("gapx", 3, 900);
    check_word("gapx_w0", 8'h11, 4);
    check_word("gapx_w1", 8'h22, 4);
    check_word("gapx_w2", 8'h33, 4);
    chk("gapx_ovr", ovr, 0);
    tick(8);

    // Qualifier held for 5 clocks gives one word
    sser_n = 1'b0; ba = addr(14'h1000); bd = 8'h96;
    tick(5);
    sser_n = 1'b1;
    wait_frames("hold5", 1, 300);
    check_word("hold5", 8'h96, 4);
    tick(100);
    chk("hold5_single", 32'(q_bits.size()), 0);

    // Wrong window, read cycle, unmapped offset: all ignored
    bus_write(14'h3000, 8'h12, 1'b0);
    bus_write(14'h1000, 8'h34, 1'b1);
    bus_write(14'h1020, 8'h56, 1'b0);
    chk("ignored_busy", busy, 0);
    tick(100);
    chk("ignored_none", 32'(q_bits.size()), 0);

    // Reset in the middle of 8'h81
    bus_write(14'h1000, 8'h81, 1'b0);
    k = 0;
    while (m_nb < 5 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk("midrst_reached_bit3", 32'(m_nb >= 5), 1);
    dc = done_cnt;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sdwr", sdwr, 1);
    chk("midrst_sclk", sclk_o, 0);
    chk("midrst_sframe_n", sframe_n, 0 + 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick(3);
    rst_n = 1'b1;
    tick(60);
    chk("midrst_no_done", 32'(done_cnt), 32'(dc));
    chk("midrst_no_frame", 32'(q_bits.size()), 0);
    bus_write(14'h1000, 8'h5A, 1'b0);
    wait_frames("after_rst", 1, 300);
    check_word("after_rst", 8'h5A, 4);
    tick(8);

`ifdef SER_SDWR_PARITY_EN
    bus_write(14'h1000, 8'h07, 1'b0);
    wait_frames("par07", 1, 300);
    if (q_bits.size() > 0) begin
      w = q_bits[0];
      chk("par07_ninth", 32'(w[0]), 0);
    end
    check_word("par07", 8'h07, 4);
    tick(8);
    bus_write(14'h1000, 8'h03, 1'b0);
    wait_frames("par03", 1, 300);
    if (q_bits.size() > 0) begin
      w = q_bits[0];
      chk("par03_ninth", 32'(w[0]), 1);
    end
    check_word("par03", 8'h03, 4);
    tick(8);
`else
    w = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
